sbox_inv_ti_serial: RTL and testbench
=====================================

SBOX_INV_TI_SERIAL -- requirements
Module: sbox_inv_ti_serial

Interface
REQ-001 Parameter: NLANES, default 32, number of 5-bit lanes per share. The state width W = 5*NLANES, 160 at default.
REQ-002 Port: clk, input, 1, sole clock; all registers update on its rising edge.
REQ-003 Port: rst, input, 1, reset; asynchronous and active-high.
REQ-004 Port: in_valid, input, 1, a shared state is offered on a1..a4.
REQ-005 Port: in_ready, output, 1, block can accept a state.
REQ-006 Ports: a1, a2, a3, a4, each input, [0:W-1], four Boolean shares of the input state.
REQ-007 Port: out_valid, output, 1, y1..y4 hold a finished result.
REQ-008 Port: out_ready, input, 1, consumer accepts the result.
REQ-009 Ports: y1, y2, y3, y4, each output, [0:W-1], four Boolean shares of the result.
REQ-010 Lane k of any bus occupies bits [5k:5k+4]. Bit 5k is the lane MSB.

Function
REQ-011 The unshared result lane k SHALL equal Sinv(unshared input lane k). The unshared value is the XOR of the four shares.
REQ-012 Sinv for inputs 0..31 SHALL be: 1 0 14 19 10 9 18 21 17 25 27 30 29 20 12 16 23 4 13 31 8 6 28 11 22 2 3 7 15 5 24 26. This is the inverse of the forward 5-bit S-box used in the same cipher.
REQ-013 Sinv SHALL be computed as a 4-share direct sharing of its algebraic normal form (ANF), with the constant term added to share 1 only.
REQ-014 Output share i SHALL be non-complete: it depends only on input shares j != i.
REQ-015 Lane processing SHALL use one shared combinational Sinv instance. All share inputs to it SHALL come from registers.
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 In IDLE, in_ready SHALL be 1. In RUN and DONE, in_ready SHALL be 0.
REQ-018 On in_valid & in_ready, the block SHALL load a1..a4 into four W-bit share registers, clear the 5-bit lane counter, and enter RUN.
REQ-019 Each RUN cycle SHALL take lane 0 of every share register and shift each register left by 5 bits.
REQ-020 Each RUN cycle SHALL write the Sinv output shares of the extracted lane into lane NLANES-1 of the matching register, and increment the counter.
REQ-021 When the counter equals NLANES-1 during a RUN cycle, that cycle's edge SHALL move the FSM to DONE. Exactly NLANES RUN cycles occur, and lane order is restored.
REQ-022 out_valid SHALL be 1 only in DONE. It SHALL first be high NLANES+1 rising edges after the accepting edge (33 at default).
REQ-023 y1..y4 SHALL continuously reflect the share registers. Their content is defined only while out_valid=1.
REQ-024 In DONE, the registers SHALL hold until out_valid & out_ready; that edge SHALL return the FSM to IDLE.
REQ-025 out_ready while not in DONE SHALL be ignored.
REQ-026 in_valid while not in IDLE SHALL be ignored, and the offered data is not captured.
REQ-027 Back-to-back operation: a new state can be accepted no earlier than the cycle after the result handshake.
REQ-028 No fresh randomness is consumed. Output share uniformity is not required.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE, the counter 0, and all share registers 0.
REQ-030 During reset, in_ready=1, out_valid=0, and y1..y4=0, independent of clk.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation immediately. No partial result is presented, and the first post-reset cycle accepts a new state.

Verification
REQ-032 All shares zero, one transaction -> out_valid rises 33 edges after acceptance; every unshared result lane = 00001.
REQ-033 Random 4-way sharing of unshared lanes k = k (0..31) -> unshared result lane k = Sinv[k] per REQ-012 (lane 2 -> 14, lane 31 -> 26).
REQ-034 Two runs identical except a1 (then a2, a3, a4 in turn) -> y1 (resp. y2, y3, y4) bit-identical between the runs.
REQ-035 in_valid held high through RUN, out_ready held 0 for 10 cycles in DONE -> no second capture; y stable; out_valid stays 1 until out_ready=1, then IDLE the next cycle.
REQ-036 rst pulsed at RUN cycle 17 -> out_valid=0 and y=0 immediately; after release, a fresh transaction completes correctly in 33 edges.
REQ-037 Forward-S-box shared output fed back as input (four-share form) -> unshared result equals the original unshared input.

Source files
------------

// File: rtl/sbox_inv_ti_serial.sv
// Serial 4-share threshold implementation of the inverse 5-bit S-box.
// One shared Sinv instance processes one lane per cycle while the share registers rotate.
module sbox_inv_ti_serial #(
    parameter int unsigned NLANES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:5*NLANES-1]   a1,
    input  logic [0:5*NLANES-1]   a2,
    input  logic [0:5*NLANES-1]   a3,
    input  logic [0:5*NLANES-1]   a4,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:5*NLANES-1]   y1,
    output logic [0:5*NLANES-1]   y2,
    output logic [0:5*NLANES-1]   y3,
    output logic [0:5*NLANES-1]   y4
);

    localparam int unsigned W    = 5 * NLANES;
    localparam logic [4:0]  LAST = 5'(NLANES - 1);

    localparam logic [4:0] SINV_TABLE [32] = '{
        5'd1,  5'd0,  5'd14, 5'd19, 5'd10, 5'd9,  5'd18, 5'd21,
        5'd17, 5'd25, 5'd27, 5'd30, 5'd29, 5'd20, 5'd12, 5'd16,
        5'd23, 5'd4,  5'd13, 5'd31, 5'd8,  5'd6,  5'd28, 5'd11,
        5'd22, 5'd2,  5'd3,  5'd7,  5'd15, 5'd5,  5'd24, 5'd26
    };

    // Moebius transform of one output bit: bit m of the result is the ANF
    // coefficient of the monomial whose variables are the set bits of m.
    function automatic logic [31:0] anf_of_bit(input int unsigned b);
        logic [31:0] t;
        for (int unsigned x = 0; x < 32; x++) t[x] = SINV_TABLE[x][b];
        for (int unsigned i = 0; i < 5; i++)
            for (int unsigned x = 0; x < 32; x++)
                if (x[i]) t[x] = t[x] ^ t[x ^ (32'd1 << i)];
        return t;
    endfunction

    localparam logic [31:0] ANF [5] = '{
        anf_of_bit(0), anf_of_bit(1), anf_of_bit(2), anf_of_bit(3), anf_of_bit(4)
    };

    // Direct sharing: every cross-share product term of each monomial goes to the
    // lowest-numbered output share it does not touch; the constant goes to share 0.
    function automatic logic [4:0] share_out(input int unsigned idx, input logic [3:0][4:0] s);
        logic [4:0]  y;
        logic [3:0]  used;
        logic        term;
        int unsigned deg, k, sh, owner;
        y = '0;
        if (idx == 0)
            for (int unsigned b = 0; b < 5; b++) y[b] = ANF[b][0];
        for (int unsigned m = 1; m < 32; m++) begin
            deg = $countones(m[4:0]);
            for (int unsigned tup = 0; tup < 1024; tup++) begin
                if (tup < (32'd1 << (2 * deg))) begin
                    term = 1'b1;
                    used = '0;
                    k    = 0;
                    for (int unsigned v = 0; v < 5; v++) begin
                        if (m[v]) begin
                            sh            = (tup >> (2 * k)) & 32'd3;
                            term          = term & s[sh[1:0]][v];
                            used[sh[1:0]] = 1'b1;
                            k++;
                        end
                    end
                    owner = 4;
                    for (int unsigned j = 0; j < 4; j++)
                        if (!used[j] && owner == 4) owner = j;
                    if (owner == 4) owner = 0;
                    if (owner == idx)
                        for (int unsigned b = 0; b < 5; b++)
                            if (ANF[b][m]) y[b] = y[b] ^ term;
                end
            end
        end
        return y;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [4:0]       cnt;
    logic [0:W-1]     sreg [4];
    logic             load, shift;
    logic [3:0][4:0]  lane_in, lane_out, masked;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) lane_in[i] = sreg[i][0:4];
    end

    // Share i of the input is zeroed before computing output share i, so each
    // output share is structurally independent of its own input share.
    always_comb begin
        lane_out = '0;
        masked   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            masked      = lane_in;
            masked[i]   = '0;
            lane_out[i] = share_out(i, masked);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) sreg[i] <= '0;
        end else if (load) begin
            cnt     <= '0;
            sreg[0] <= a1;
            sreg[1] <= a2;
            sreg[2] <= a3;
            sreg[3] <= a4;
        end else if (shift) begin
            cnt <= cnt + 5'd1;
            for (int unsigned i = 0; i < 4; i++)
                sreg[i] <= {sreg[i][5:W-1], lane_out[i]};
        end
    end

    assign y1 = sreg[0];
    assign y2 = sreg[1];
    assign y3 = sreg[2];
    assign y4 = sreg[3];

endmodule

// File: tb/tb_sbox_inv_ti_serial.sv
// Directed bench for sbox_inv_ti_serial: vector table plus handshake, reset and share-isolation sequences.
module tb_sbox_inv_ti_serial;

    localparam int unsigned NL = 32;
    localparam int unsigned W  = 5 * NL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [0:W-1] a1, a2, a3, a4, y1, y2, y3, y4;

    always #5 clk = ~clk;

    sbox_inv_ti_serial #(.NLANES(NL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .out_valid(out_valid), .out_ready(out_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4)
    );

    int unsigned sinv_t [32] = '{1, 0, 14, 19, 10, 9, 18, 21, 17, 25, 27, 30, 29, 20, 12, 16,
                                 23, 4, 13, 31, 8, 6, 28, 11, 22, 2, 3, 7, 15, 5, 24, 26};
    int unsigned fwd_t [32];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [0:W-1] plain;
        logic [0:W-1] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [0:W-1] act, input logic [0:W-1] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [0:W-1] apply_tab(input logic [0:W-1] p, input bit inverse);
        logic [0:W-1] r;
        logic [4:0]   l;
        for (int k = 0; k < NL; k++) begin
            l = p[5*k +: 5];
            r[5*k +: 5] = inverse ? 5'(sinv_t[l]) : 5'(fwd_t[l]);
        end
        return r;
    endfunction

    function automatic logic [0:W-1] rand_vec();
        logic [0:W-1] r;
        for (int w = 0; w < 5; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic share(input logic [0:W-1] p, output logic [0:W-1] s1, s2, s3, s4);
        s1 = rand_vec();
        s2 = rand_vec();
        s3 = rand_vec();
        s4 = p ^ s1 ^ s2 ^ s3;
    endtask

    // Drives one transaction from IDLE; lat counts edges from the accepting edge inclusive.
    task automatic run_txn(input logic [0:W-1] s1, s2, s3, s4,
                           output logic [0:W-1] r1, r2, r3, r4, output int lat);
        @(negedge clk);
        a1 = s1; a2 = s2; a3 = s3; a4 = s4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r1 = y1; r2 = y2; r3 = y3; r4 = y4;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [0:W-1] s1, s2, s3, s4, r1, r2, r3, r4, p, q1, q2, q3, q4, res;
    logic [0:W-1] bs [4];
    logic [0:W-1] alt [4];
    logic [0:W-1] rs [4];
    logic [0:W-1] held;
    logic [4:0]   lane;
    int           lat;

    initial begin
        for (int x = 0; x < 32; x++) fwd_t[sinv_t[x]] = x;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '1; a2 = '1; a3 = '0; a4 = '1;
        #2;
        chk_int("reset_in_ready", int'(in_ready), 1);
        chk_int("reset_out_valid", int'(out_valid), 0);
        chk("reset_y", y1 | y2 | y3 | y4, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs[0].plain = '0;
        for (int k = 0; k < NL; k++) vecs[0].exp[5*k +: 5] = 5'b00001;
        for (int k = 0; k < NL; k++) vecs[1].plain[5*k +: 5] = 5'(k);
        vecs[1].exp = apply_tab(vecs[1].plain, 1'b1);
        for (int k = 0; k < NL; k++) vecs[2].plain[5*k +: 5] = 5'(31 - k);
        vecs[2].exp = apply_tab(vecs[2].plain, 1'b1);
        vecs[3].plain = '1;
        for (int k = 0; k < NL; k++) vecs[3].exp[5*k +: 5] = 5'd26;
        vecs[4].plain = rand_vec();
        vecs[4].exp = apply_tab(vecs[4].plain, 1'b1);

        for (int v = 0; v < 5; v++) begin
            if (v == 0) begin
                s1 = '0; s2 = '0; s3 = '0; s4 = '0;
            end else begin
                share(vecs[v].plain, s1, s2, s3, s4);
            end
            run_txn(s1, s2, s3, s4, r1, r2, r3, r4, lat);
            res = r1 ^ r2 ^ r3 ^ r4;
            chk_int($sformatf("vec%0d_latency", v), lat, NL + 1);
            chk($sformatf("vec%0d_result", v), res, vecs[v].exp);
            chk_int($sformatf("vec%0d_idle_after", v), int'(in_ready), 1);
            if (v == 1) begin
                lane = res[10 +: 5];
                chk_int("lane2_is_14", int'(lane), 14);
                lane = res[155 +: 5];
                chk_int("lane31_is_26", int'(lane), 26);
            end
        end

        // Output share i must not change when only input share i changes.
        p = rand_vec();
        share(p, bs[0], bs[1], bs[2], bs[3]);
        run_txn(bs[0], bs[1], bs[2], bs[3], rs[0], rs[1], rs[2], rs[3], lat);
        for (int i = 0; i < 4; i++) begin
            alt = bs;
            alt[i] = rand_vec();
            run_txn(alt[0], alt[1], alt[2], alt[3], r1, r2, r3, r4, lat);
            case (i)
                0: chk("noncomplete_y1", r1, rs[0]);
                1: chk("noncomplete_y2", r2, rs[1]);
                2: chk("noncomplete_y3", r3, rs[2]);
                default: chk("noncomplete_y4", r4, rs[3]);
            endcase
        end

        // in_valid held through RUN with other data; result held while out_ready low.
        p = rand_vec();
        share(p, s1, s2, s3, s4);
        share(rand_vec(), q1, q2, q3, q4);
        @(negedge clk);
        a1 = s1; a2 = s2; a3 = s3; a4 = s4;
        in_valid = 1'b1;
        @(negedge clk);
        a1 = q1; a2 = q2; a3 = q3; a4 = q4;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk_int("hold_latency", lat, NL + 1);
        held = y1;
        chk("hold_result", y1 ^ y2 ^ y3 ^ y4, apply_tab(p, 1'b1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_int($sformatf("hold_valid_c%0d", c), int'(out_valid), 1);
            chk($sformatf("hold_y1_c%0d", c), y1, held);
        end
        chk_int("hold_in_ready_done", int'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_int("hold_idle_next", int'(in_ready), 1);
        chk_int("hold_valid_dropped", int'(out_valid), 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk_int("hold_no_recapture", int'(in_ready), 1);

        // Reset in the middle of RUN aborts; next transaction completes normally.
        share(rand_vec(), s1, s2, s3, s4);
        @(negedge clk);
        a1 = s1; a2 = s2; a3 = s3; a4 = s4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_int("abort_out_valid", int'(out_valid), 0);
        chk_int("abort_in_ready", int'(in_ready), 1);
        chk("abort_y", y1 | y2 | y3 | y4, '0);
        @(negedge clk);
        rst = 1'b0;
        p = rand_vec();
        share(p, s1, s2, s3, s4);
        run_txn(s1, s2, s3, s4, r1, r2, r3, r4, lat);
        chk_int("post_abort_latency", lat, NL + 1);
        chk("post_abort_result", r1 ^ r2 ^ r3 ^ r4, apply_tab(p, 1'b1));

        // Forward S-box output in shared form must invert back to the plaintext.
        p = rand_vec();
        share(apply_tab(p, 1'b0), s1, s2, s3, s4);
        run_txn(s1, s2, s3, s4, r1, r2, r3, r4, lat);
        chk("roundtrip", r1 ^ r2 ^ r3 ^ r4, p);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
